wb_irqc: RTL and testbench

//  Wishbone interrupt controller in the peripheral decode window. Collects up to 32

---
 rtl/irqc_pkg.sv | 12 +
 rtl/irq_sync.sv | 31 +++
 rtl/wb_irqc.sv | 99 +++++++++
 tb/tb_wb_irqc.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/irqc_pkg.sv
// irqc_pkg: register offsets, FSM states and priority helper shared by the interrupt controller.
package irqc_pkg;
  localparam logic [1:0] IRQC_PENDING = 2'd0;
  localparam logic [1:0] IRQC_ENABLE  = 2'd1;
  localparam logic [1:0] IRQC_EDGE    = 2'd2;
  localparam logic [1:0] IRQC_STATUS  = 2'd3;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    lowest_idx = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_idx = 5'(i);
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: synchroniser for one asynchronous interrupt line plus a registered rising-edge pulse.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic lvl_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end
  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;
endmodule

// File: rtl/wb_irqc.sv
// wb_irqc: Wishbone interrupt controller with fixed-priority arbitration and a req/ack/gap
// handshake towards the CPU interface.
module wb_irqc
  import irqc_pkg::*;
#(
  parameter int SOURCES     = 8,
  parameter int VEC_BASE    = 25,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [29:0]        adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic               ack_o,
  output logic [31:0]        dat_o,
  input  logic [SOURCES-1:0] irq_src,
  output logic               irq_req,
  output logic [7:0]         irq_vec,
  input  logic               irq_ack
);
  logic [SOURCES-1:0] lvl, rise, wmask, wdat, clr, cand;
  logic [SOURCES-1:0] pend_q, pend_d, en_q, en_d, edg_q, edg_d;
  logic [31:0] m32, rd, dat_q, dat_d;
  logic [7:0] vec_q, vec_d;
  logic [4:0] idx_q, idx_d;
  logic ack_q, ack_d, acc, wr;
  state_e state_q, state_d;

  for (genvar i = 0; i < SOURCES; i++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .src_i (irq_src[i]),
      .lvl_o (lvl[i]),
      .rise_o(rise[i])
    );
  end

  always_comb begin
    acc   = cyc_i & stb_i & ~ack_q;
    wr    = acc & we_i;
    m32   = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    wmask = m32[SOURCES-1:0];
    wdat  = dat_i[SOURCES-1:0] & wmask;
    en_d  = (wr && adr_i[1:0] == IRQC_ENABLE) ? (en_q & ~wmask) | wdat : en_q;
    edg_d = (wr && adr_i[1:0] == IRQC_EDGE) ? (edg_q & ~wmask) | wdat : edg_q;
    // a mode switch drops the bit; a new edge still wins over any same-cycle clear
    clr   = ((wr && adr_i[1:0] == IRQC_PENDING) ? wdat : '0) | (edg_q ^ edg_d) |
            ((state_q == REQ && irq_ack) ? SOURCES'(1) << idx_q : '0);
    pend_d = (edg_d & ((pend_q & ~clr) | rise)) | (~edg_d & lvl);
    rd    = adr_i[1:0] == IRQC_PENDING ? 32'(pend_q) :
            adr_i[1:0] == IRQC_ENABLE  ? 32'(en_q) :
            adr_i[1:0] == IRQC_EDGE    ? 32'(edg_q) :
            {state_q == REQ, 23'b0, vec_q};
    dat_d = acc ? rd : '0;
    ack_d = acc;
    cand  = pend_q & en_q;
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    if (state_q == IDLE && |cand) begin
      idx_d   = lowest_idx(32'(cand));
      vec_d   = 8'(VEC_BASE) + {3'b0, idx_d};
      state_d = REQ;
    end else if (state_q == REQ && irq_ack) state_d = GAP;
    else if (state_q == GAP) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      en_q    <= '0;
      edg_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      vec_q   <= '0;
      idx_q   <= '0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      edg_q   <= edg_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign irq_req = state_q == REQ;
  assign irq_vec = vec_q;
endmodule

// File: tb/tb_wb_irqc.sv
// tb_wb_irqc: directed bench for wb_irqc; expected read data and vectors go through a scoreboard queue.
module tb_wb_irqc;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic cyc_i = 0, stb_i = 0, we_i = 0, irq_ack = 0;
  logic [29:0] adr_i = '0;
  logic [3:0] sel_i = '0;
  logic [31:0] dat_i = '0, dat_o;
  logic ack_o, irq_req;
  logic [7:0] irq_src = 8'hFF, irq_vec;
  logic [31:0] sb[$];
  int checks = 0, errors = 0;

  wb_irqc dut (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
    .irq_src(irq_src), .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb(input string tag, input logic w, input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] e;
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = w; adr_i = {28'b0, a}; dat_i = d; sel_i = s;
    @(negedge clk);
    chk({tag, "_ack"}, {31'b0, ack_o}, 32'd1);
    if (!w) begin
      e = sb.pop_front();
      chk(tag, dat_o, e);
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    @(negedge clk);
    chk({tag, "_ackpulse"}, {31'b0, ack_o}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    wb(tag, 1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic expect_irq(input string tag);
    int n = 0;
    logic [31:0] e;
    while (!irq_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'b0, irq_req}, 32'd1);
    e = sb.pop_front();
    chk(tag, {24'b0, irq_vec}, e);
  endtask

  task automatic do_ack(input string tag);
    irq_ack = 1;
    @(negedge clk);
    irq_ack = 0;
    chk({tag, "_gap"}, {31'b0, irq_req}, 32'd0);
  endtask

  initial begin
    cycles(3);
    chk("rst_req", {31'b0, irq_req}, 32'd0);
    chk("rst_vec", {24'b0, irq_vec}, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_ni = 1; irq_src = '0;
    rd("rst_pend", 2'd0, 32'h0);
    rd("rst_en", 2'd1, 32'h0);
    rd("rst_edge", 2'd2, 32'h0);
    rd("rst_stat", 2'd3, 32'h0);

    wb("edge0c", 1'b1, 2'd2, 32'h0C, 4'hF);
    @(negedge clk) irq_src = 8'h08;
    @(negedge clk) irq_src = 8'h04;
    @(negedge clk) irq_src = 8'h00;
    cycles(6);
    rd("pend0c", 2'd0, 32'h0C);
    sb.push_back(32'd27);
    sb.push_back(32'd28);
    wb("en0c", 1'b1, 2'd1, 32'h0C, 4'hF);
    expect_irq("vec27");
    do_ack("ack27");
    expect_irq("vec28");
    do_ack("ack28");
    cycles(3);
    chk("idle_after28", {31'b0, irq_req}, 32'd0);
    rd("pend_clr", 2'd0, 32'h0);

    wb("edge0", 1'b1, 2'd2, 32'h0, 4'hF);
    wb("en1", 1'b1, 2'd1, 32'h1, 4'hF);
    sb.push_back(32'd25);
    irq_src = 8'h01;
    expect_irq("lvl25");
    sb.push_back(32'd25);
    do_ack("lvl_ack1");
    expect_irq("lvl_rereq");
    irq_src = 8'h00;
    cycles(5);
    do_ack("lvl_ack2");
    cycles(5);
    chk("lvl_noreq", {31'b0, irq_req}, 32'd0);
    rd("lvl_pend", 2'd0, 32'h0);

    wb("edge2", 1'b1, 2'd2, 32'h2, 4'hF);
    wb("en2", 1'b1, 2'd1, 32'h2, 4'hF);
    sb.push_back(32'd26);
    @(negedge clk) irq_src = 8'h02;
    @(negedge clk) irq_src = 8'h00;
    expect_irq("vec26");
    wb("en_off", 1'b1, 2'd1, 32'h0, 4'hF);
    chk("hold_req", {31'b0, irq_req}, 32'd1);
    chk("hold_vec", {24'b0, irq_vec}, 32'd26);
    do_ack("ack26");
    cycles(4);
    chk("noreq26", {31'b0, irq_req}, 32'd0);
    rd("pend26", 2'd0, 32'h0);

    wb("edge20", 1'b1, 2'd2, 32'h20, 4'hF);
    @(negedge clk) irq_src = 8'h20;
    @(negedge clk) irq_src = 8'h00;
    @(negedge clk);
    wb("w1c_race", 1'b1, 2'd0, 32'h20, 4'hF);
    rd("set_wins", 2'd0, 32'h20);
    wb("w1c", 1'b1, 2'd0, 32'h20, 4'hF);
    rd("w1c_done", 2'd0, 32'h0);

    wb("stat_w", 1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF);
    rd("stat_r", 2'd3, 32'h0000_001A);
    wb("en_lane0", 1'b1, 2'd1, 32'hFFFF_FFFF, 4'b0001);
    rd("en_ff", 2'd1, 32'h0000_00FF);
    wb("en_lane1", 1'b1, 2'd1, 32'h0, 4'b0010);
    rd("en_keep", 2'd1, 32'h0000_00FF);
    cycles(2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
